// File: rtl/mux_sel_pkg.sv
// Shared mode encoding, parameter limits and slice helper for param_mux_sel.
package mux_sel_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int NUM_INPUTS_MIN = 2;
    localparam int NUM_INPUTS_MAX = 256;

    // Low bit of channel idx inside the flattened input bus.
    function automatic int slice_lo(int idx, int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/param_mux_sel_if.sv
// Request/response bus of param_mux_sel; chan_mask exists only when
// MUX_SEL_CHANNEL_MASK_EN is defined.
interface param_mux_sel_if #(
    parameter int NUM_INPUTS = 32,
    parameter int DATA_W     = 2
);
    import mux_sel_pkg::*;

    localparam int SEL_W = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS*DATA_W-1:0] inp;
    logic [SEL_W-1:0]             sel;
    mode_e                        mode;
    logic                         scan_clr;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            out;
    logic [SEL_W-1:0]             out_sel;
    logic                         out_last;
    logic                         sel_err;
    logic                         out_valid;
    logic                         out_ready;
`ifdef MUX_SEL_CHANNEL_MASK_EN
    logic [NUM_INPUTS-1:0]        chan_mask;
`endif

    modport master (
        output inp, sel, mode, scan_clr, in_valid, out_ready,
`ifdef MUX_SEL_CHANNEL_MASK_EN
        output chan_mask,
`endif
        input  in_ready, out, out_sel, out_last, sel_err, out_valid
    );

    modport slave (
        input  inp, sel, mode, scan_clr, in_valid, out_ready,
`ifdef MUX_SEL_CHANNEL_MASK_EN
        input  chan_mask,
`endif
        output in_ready, out, out_sel, out_last, sel_err, out_valid
    );

endinterface

// File: rtl/mux_sel_next_chan.sv
// Circular next-enabled-channel finder; with MUX_SEL_CHANNEL_MASK_EN undefined
// it is a plain increment-with-wrap.
module mux_sel_next_chan #(
    parameter int NUM_INPUTS = 32,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic [SEL_W-1:0]      ptr_i,
`ifdef MUX_SEL_CHANNEL_MASK_EN
    input  logic [NUM_INPUTS-1:0] mask_i,
`endif
    output logic [SEL_W-1:0]      cur_o,
    output logic [SEL_W-1:0]      next_o,
    output logic                  wrap_o,
    output logic                  none_o
);

`ifdef MUX_SEL_CHANNEL_MASK_EN
    int               idx;
    int               hi;
    logic [SEL_W-1:0] idx_s;

    // NOTE: every variable gets a default before the loops so no latch is inferred.
    always_comb begin
        cur_o  = ptr_i;
        none_o = 1'b1;
        hi     = 0;
        idx    = 0;
        idx_s  = '0;
        // Walk downwards so the closest enabled channel at or after ptr wins.
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            idx_s = idx[SEL_W-1:0];
            if (!mask_i[idx_s]) begin
                cur_o  = idx_s;
                none_o = 1'b0;
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!mask_i[i]) hi = i;
        end
    end

    assign wrap_o = !none_o && (int'(cur_o) == hi);
`else
    assign cur_o  = ptr_i;
    assign none_o = 1'b0;
    assign wrap_o = (ptr_i == SEL_W'(NUM_INPUTS - 1));
`endif

    assign next_o = (int'(cur_o) == NUM_INPUTS - 1) ? '0 : cur_o + 1'b1;

endmodule

// File: rtl/param_mux_sel.sv
// Registered N-to-1 channel selector with direct/scan modes and a one-entry
// valid/ready output stage. Optional channel masking: MUX_SEL_CHANNEL_MASK_EN.
module param_mux_sel
    import mux_sel_pkg::*;
#(
    parameter int NUM_INPUTS = 32,
    parameter int DATA_W     = 2
) (
    input  logic          clk,
    input  logic          reset,
    param_mux_sel_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_INPUTS);

    if (NUM_INPUTS < NUM_INPUTS_MIN || NUM_INPUTS > NUM_INPUTS_MAX) begin : g_bad_num_inputs
        $error("param_mux_sel: NUM_INPUTS out of range");
    end

    logic [DATA_W-1:0] out_q, out_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_last_q, out_last_d;
    logic              sel_err_q, sel_err_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic [SEL_W-1:0]  ptr_eff, cur, nxt;
    logic              wrap, none, sel_ok, accept;

    // A same-cycle scan_clr makes the scan start from channel 0.
    assign ptr_eff = bus.scan_clr ? '0 : ptr_q;

    mux_sel_next_chan #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W)
    ) u_next_chan (
        .ptr_i  (ptr_eff),
`ifdef MUX_SEL_CHANNEL_MASK_EN
        .mask_i (bus.chan_mask),
`endif
        .cur_o  (cur),
        .next_o (nxt),
        .wrap_o (wrap),
        .none_o (none)
    );

`ifdef MUX_SEL_CHANNEL_MASK_EN
    assign sel_ok = (int'(bus.sel) < NUM_INPUTS) && !bus.chan_mask[bus.sel];
`else
    assign sel_ok = (int'(bus.sel) < NUM_INPUTS);
`endif

    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !(bus.mode == MODE_SCAN && none);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        sel_err_d   = sel_err_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        ptr_d       = ptr_eff;
        if (accept) begin
            out_valid_d = 1'b1;
            if (bus.mode == MODE_SCAN) begin
                out_d      = bus.inp[slice_lo(int'(cur), DATA_W) +: DATA_W];
                out_sel_d  = cur;
                out_last_d = wrap;
                sel_err_d  = 1'b0;
                ptr_d      = nxt;
            end else begin
                out_sel_d  = bus.sel;
                out_last_d = 1'b0;
                sel_err_d  = !sel_ok;
                out_d      = sel_ok ? bus.inp[slice_lo(int'(bus.sel), DATA_W) +: DATA_W] : '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
            sel_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            sel_err_q   <= sel_err_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_last  = out_last_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_param_mux_sel.sv
// Randomised bench for param_mux_sel (24 channels, 2-bit data) against a
// behavioural model; mask scenarios run when MUX_SEL_CHANNEL_MASK_EN is defined.
module tb_param_mux_sel;
    import mux_sel_pkg::*;

    localparam int N  = 24;
    localparam int W  = 2;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_mux_sel_if #(.NUM_INPUTS(N), .DATA_W(W)) bus ();

    param_mux_sel #(.NUM_INPUTS(N), .DATA_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] chan [N];
    logic [N-1:0] mask_v;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the output register and scan pointer.
    bit m_valid, m_last, m_err;
    int m_out, m_sel, m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int first_en(int from);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (from + i) % N;
            if (!mask_v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int highest_en();
        for (int c = N - 1; c >= 0; c--) if (!mask_v[c]) return c;
        return -1;
    endfunction

    task automatic cycle();
        bit rdy, acc;
        int c, s;
        for (int k = 0; k < N; k++) bus.inp[k*W +: W] = chan[k];
`ifdef MUX_SEL_CHANNEL_MASK_EN
        bus.chan_mask = mask_v;
`endif
        #2;
        rdy = (!m_valid || bus.out_ready) && !(bus.mode == MODE_SCAN && first_en(0) < 0);
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        @(posedge clk);
        acc = bus.in_valid && rdy;
        if (reset) begin
            m_valid = 0; m_last = 0; m_err = 0; m_out = 0; m_sel = 0; m_ptr = 0;
        end else begin
            if (m_valid && bus.out_ready) m_valid = 0;
            if (bus.scan_clr) m_ptr = 0;
            if (acc) begin
                m_valid = 1;
                if (bus.mode == MODE_SCAN) begin
                    c      = first_en(m_ptr);
                    m_out  = chan[c];
                    m_sel  = c;
                    m_last = (c == highest_en());
                    m_err  = 0;
                    m_ptr  = (c + 1) % N;
                end else begin
                    s      = int'(bus.sel);
                    m_sel  = s;
                    m_last = 0;
                    m_out  = 0;
                    m_err  = 1;
                    if (s < N) begin
                        if (!mask_v[s]) begin
                            m_out = chan[s];
                            m_err = 0;
                        end
                    end
                end
            end
        end
        #1;
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("out", 32'(bus.out), 32'(m_out));
            check("out_sel", 32'(bus.out_sel), 32'(m_sel));
            check("out_last", {31'd0, bus.out_last}, {31'd0, m_last});
            check("sel_err", {31'd0, bus.sel_err}, {31'd0, m_err});
        end
    endtask

    initial begin
        reset        = 1'b1;
        mask_v       = '0;
        bus.sel      = '0;
        bus.mode     = MODE_DIRECT;
        bus.scan_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) chan[k] = W'(k % 4);
        m_valid = 0; m_last = 0; m_err = 0; m_out = 0; m_sel = 0; m_ptr = 0;
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_out_sel", 32'(bus.out_sel), 32'd0);
        check("rst_flags", {30'd0, bus.out_last, bus.sel_err}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Direct mode, in-range then out-of-range select.
        bus.in_valid = 1'b1;
        bus.sel      = SW'(5);
        cycle();
        check("direct5_out", 32'(bus.out), 32'd1);
        check("direct5_sel", 32'(bus.out_sel), 32'd5);
        check("direct5_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.sel = SW'(27);
        cycle();
        check("oor_out", 32'(bus.out), 32'd0);
        check("oor_err", {31'd0, bus.sel_err}, 32'd1);

        // Full scan with wrap on a non-power-of-two channel count.
        bus.mode = MODE_SCAN;
        for (int i = 0; i < 25; i++) begin
            cycle();
            check("scan_sel", 32'(bus.out_sel), 32'(i % N));
            check("scan_last", {31'd0, bus.out_last}, {31'd0, (i % N) == N - 1});
        end

        // Back-pressure: held sample survives input changes, then no bubble.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) chan[k] = W'($urandom);
            cycle();
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
        end

        // scan_clr alone, then with an accept at ptr=10.
        bus.in_valid = 1'b0;
        bus.scan_clr = 1'b1;
        cycle();
        bus.scan_clr = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        bus.scan_clr = 1'b1;
        cycle();
        check("clr_acc_sel", 32'(bus.out_sel), 32'd0);
        bus.scan_clr = 1'b0;
        cycle();
        check("clr_next_sel", 32'(bus.out_sel), 32'd1);

        // Reset while a sample is held.
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_out", 32'(bus.out), 32'd0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        check("midrst_scan_sel", 32'(bus.out_sel), 32'd0);

`ifdef MUX_SEL_CHANNEL_MASK_EN
        // Only channels 1 and 3 enabled.
        mask_v = N'(32'hFFFF_FFF5);
        bus.in_valid = 1'b0;
        bus.scan_clr = 1'b1;
        cycle();
        bus.scan_clr = 1'b0;
        bus.in_valid = 1'b1;
        cycle();
        check("mask_sel_a", 32'(bus.out_sel), 32'd1);
        check("mask_last_a", {31'd0, bus.out_last}, 32'd0);
        cycle();
        check("mask_sel_b", 32'(bus.out_sel), 32'd3);
        check("mask_last_b", {31'd0, bus.out_last}, 32'd1);
        cycle();
        check("mask_sel_c", 32'(bus.out_sel), 32'd1);
        mask_v = '1;
        cycle();
        check("mask_all_rdy", {31'd0, bus.in_ready}, 32'd0);
        mask_v = '0;
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.mode      = mode_e'($urandom_range(0, 1));
            bus.sel       = SW'($urandom_range(0, 31));
            bus.scan_clr  = ($urandom_range(0, 15) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < N; k++) chan[k] = W'($urandom);
`ifdef MUX_SEL_CHANNEL_MASK_EN
            if ($urandom_range(0, 19) == 0) mask_v = '1;
            else if ($urandom_range(0, 3) == 0) mask_v = N'($urandom);
            else mask_v = '0;
`endif
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_mux_sel.md
# param_mux_sel

Parametrised, registered N-to-1 channel selector with a valid/ready output stage. It generalises the team's fixed 32-input, 2-bit combinational mux to any channel count and data width. It adds an auto-scan mode that steps through channels in order, and it flags out-of-range selects. It sits between a bank of slow status/data lanes and a single downstream consumer that drains one sample per handshake.

## Interface
Parameters:
- NUM_INPUTS, 32: channel count, 2 to 256.
- DATA_W, 2: bits per channel.
- SEL_W, $clog2(NUM_INPUTS): select width; derived, never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inp  in  NUM_INPUTS*DATA_W  flattened channels; channel k occupies bits [k*DATA_W +: DATA_W].
- sel  in  SEL_W  channel index; used in direct mode only.
- mode  in  1  0 = direct, 1 = scan; sampled on accept.
- scan_clr  in  1  resets the scan pointer to channel 0.
- in_valid  in  1  sample request.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- out  out  DATA_W  captured channel data.
- out_sel  out  SEL_W  index of the captured channel.
- out_last  out  1  set when a scan sample is the final channel before wrap.
- sel_err  out  1  set when a direct sample used an out-of-range sel.
- out_valid  out  1  output holds a sample.
- out_ready  in  1  consumer accepts the sample.

## Operation
- One-entry output register: in_ready = !out_valid || out_ready, combinational.
- Accept, direct mode: capture inp[sel] and sel. If sel >= NUM_INPUTS: out = 0, sel_err = 1. Otherwise sel_err = 0. out_last = 0.
- Accept, scan mode: capture inp[ptr] and ptr, with sel_err = 0. ptr advances circularly, so NUM_INPUTS-1 wraps to 0; non-power-of-two counts wrap correctly. out_last = 1 when the capture wrapped ptr.
- scan_clr takes priority within its cycle:
  - With a scan accept in the same cycle: channel 0 is sampled and ptr becomes 1.
  - Without an accept: ptr becomes 0.
- ptr is retained across direct-mode accepts and mode changes.
- Handshake fields (out, out_sel, out_last, sel_err) are stable while out_valid && !out_ready.
- The consumer releases on out_valid && out_ready. A simultaneous accept loads the next sample in the same edge, so there is no bubble.
- Reset values: out = 0, out_sel = 0, out_last = 0, sel_err = 0, out_valid = 0, ptr = 0. in_ready is 1 after reset.
- Reset asserted mid-transaction discards any held sample; the consumer must not see it.

## Timing
- Latency: accept at edge t, so out_valid and data are visible after edge t.
- Throughput: 1 sample per cycle when out_ready is held high.
- inp is sampled only at the accept edge. Later input changes do not affect a held sample.
- No combinational path from inp or sel to out. The only combinational path is out_ready to in_ready.

## Configuration
- MUX_SEL_CHANNEL_MASK_EN: adds input chan_mask [NUM_INPUTS-1:0], where 1 = channel disabled.
- Scan mode with the macro:
  - ptr skips masked channels, searching circularly from the current position.
  - out_last marks the highest-index enabled channel.
  - If every channel is masked, in_ready is low while mode = 1.
- Direct mode with the macro: a masked sel behaves as out-of-range (out = 0, sel_err = 1).
- Without the macro: no chan_mask port; every channel is enabled.

## Structure
- Package mux_sel_pkg holds:
  - MODE_DIRECT and MODE_SCAN constants.
  - Parameter range limits.
  - A function for the flattened-slice index.
- Sub-module mux_sel_next_chan: a combinational circular next-enabled-channel finder. Inputs are the current ptr and the mask; outputs are next ptr, wrap flag and none-enabled. Without the macro it reduces to increment-with-wrap.

## Test plan
- Reset, then direct mode, NUM_INPUTS=32, DATA_W=2, channel k = k%4, sel=5, out_ready=1 → out=2'b01, out_sel=5, out_valid one cycle after accept.
- NUM_INPUTS=24, direct sel=27 → out=0, sel_err=1. Scan of 25 accepts → out_sel 0..23 then 0, with out_last on the 23 sample.
- out_ready low for 4 cycles while inp changes → out and out_sel stable, in_ready=0, no accept. Raise out_ready with in_valid high → back-to-back transfer, no bubble.
- Scan at ptr=10 with scan_clr and accept in the same cycle → out_sel=0; next accept gives out_sel=1.
- Reset asserted with out_valid=1 → the next cycle has out_valid=0, out=0, and a scan accept gives out_sel=0.
- MUX_SEL_CHANNEL_MASK_EN, mask=32'hFFFF_FFF5 (channels 1 and 3 enabled) → scan yields 1, 3, 1 with out_last on 3. mask all ones → in_ready=0 in scan mode.
